// File: rtl/decode_stage.sv
// decode_stage: IF/ID register, RV32I decode, 32x32 register file with
// write-through bypass, branch/jump resolution and the ID/EX register.
module decode_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] if_instruction,
   input  logic [31:0] if_pc,
   input  logic        stall,
   input  logic        wb_we,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   output logic        branch_taken,
   output logic [31:0] branch_target,
   output logic        id_ex_valid,
   output logic [31:0] id_ex_pc,
   output logic [31:0] id_ex_a,
   output logic [31:0] id_ex_b,
   output logic [31:0] id_ex_store_data,
   output logic [4:0]  id_ex_rd,
   output logic [3:0]  id_ex_alu_op,
   output logic [2:0]  id_ex_funct3,
   output logic        id_ex_mem_read,
   output logic        id_ex_mem_write,
   output logic        id_ex_reg_write,
   output logic        id_ex_illegal
);
   localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLL = 4'd2, OP_SLT = 4'd3,
                          OP_SLTU = 4'd4, OP_XOR = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                          OP_OR = 4'd8, OP_AND = 4'd9;

   logic        ifid_valid;
   logic [31:0] ifid_instr, ifid_pc;
   logic [31:0] regs [32];

   logic [6:0]  opcode;
   logic [4:0]  rs1, rs2, rd;
   logic [2:0]  funct3;
   logic        f7b5;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] rs1_val, rs2_val;
   logic [31:0] d_a, d_b;
   logic [3:0]  d_op, f3_op;
   logic [4:0]  d_rd;
   logic        d_rw, d_mr, d_mw, d_ill, jump, cond;

   assign opcode = ifid_instr[6:0];
   assign rd     = ifid_instr[11:7];
   assign funct3 = ifid_instr[14:12];
   assign rs1    = ifid_instr[19:15];
   assign rs2    = ifid_instr[24:20];
   assign f7b5   = ifid_instr[30];
   assign imm_i  = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
   assign imm_s  = {{20{ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
   assign imm_b  = {{20{ifid_instr[31]}}, ifid_instr[7], ifid_instr[30:25], ifid_instr[11:8], 1'b0};
   assign imm_u  = {ifid_instr[31:12], 12'd0};
   assign imm_j  = {{12{ifid_instr[31]}}, ifid_instr[19:12], ifid_instr[20], ifid_instr[30:21], 1'b0};

   // Register reads see a same-cycle write-back through the bypass; x0 is hardwired zero.
   assign rs1_val = (rs1 == 5'd0) ? 32'd0 : (wb_we && wb_rd == rs1) ? wb_data : regs[rs1];
   assign rs2_val = (rs2 == 5'd0) ? 32'd0 : (wb_we && wb_rd == rs2) ? wb_data : regs[rs2];

   // IF/ID capture; a taken redirect squashes the wrong-path fetch behind it.
   always_ff @(posedge clk) begin
      if (reset) begin
         ifid_valid <= 1'b0;
         ifid_instr <= 32'h0000_0013;
         ifid_pc    <= 32'd0;
      end else if (!stall) begin
         ifid_valid <= !branch_taken;
         ifid_instr <= if_instruction;
         ifid_pc    <= if_pc;
      end
   end

   // Register file write port; writes to x0 are dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      end else if (wb_we && wb_rd != 5'd0) begin
         regs[wb_rd] <= wb_data;
      end
   end

   // funct3 to ALU op for the non-alternate encodings.
   always_comb begin
      f3_op = OP_ADD;
      case (funct3)
         3'b000: f3_op = OP_ADD;
         3'b001: f3_op = OP_SLL;
         3'b010: f3_op = OP_SLT;
         3'b011: f3_op = OP_SLTU;
         3'b100: f3_op = OP_XOR;
         3'b101: f3_op = OP_SRL;
         3'b110: f3_op = OP_OR;
         3'b111: f3_op = OP_AND;
         default: f3_op = OP_ADD;
      endcase
   end

   // Main decode: operand muxing, control, branch condition and redirect target.
   always_comb begin
      d_a = rs1_val;
      d_b = rs2_val;
      d_op = OP_ADD;
      d_rd = rd;
      d_rw = 1'b0;
      d_mr = 1'b0;
      d_mw = 1'b0;
      d_ill = 1'b0;
      jump = 1'b0;
      cond = 1'b0;
      branch_target = ifid_pc + imm_b;
      case (opcode)
         7'b0110011: begin
            d_op = f3_op;
            if (f7b5 && funct3 == 3'b000) d_op = OP_SUB;
            if (f7b5 && funct3 == 3'b101) d_op = OP_SRA;
            d_rw = 1'b1;
         end
         7'b0010011: begin
            d_b = imm_i;
            d_op = f3_op;
            if (f7b5 && funct3 == 3'b101) d_op = OP_SRA;
            d_rw = 1'b1;
         end
         7'b0000011: begin
            d_b = imm_i;
            d_mr = 1'b1;
            d_rw = 1'b1;
         end
         7'b0100011: begin
            d_b = imm_s;
            d_mw = 1'b1;
            d_rd = 5'd0;
         end
         7'b1100011: begin
            d_rd = 5'd0;
            case (funct3)
               3'b000: cond = (rs1_val == rs2_val);
               3'b001: cond = (rs1_val != rs2_val);
               3'b100: cond = ($signed(rs1_val) < $signed(rs2_val));
               3'b101: cond = ($signed(rs1_val) >= $signed(rs2_val));
               3'b110: cond = (rs1_val < rs2_val);
               3'b111: cond = (rs1_val >= rs2_val);
               default: d_ill = 1'b1;
            endcase
         end
         7'b1101111: begin
            d_a = ifid_pc;
            d_b = 32'd4;
            d_rw = 1'b1;
            jump = 1'b1;
            branch_target = ifid_pc + imm_j;
         end
         7'b1100111: begin
            d_a = ifid_pc;
            d_b = 32'd4;
            d_rw = 1'b1;
            jump = 1'b1;
            branch_target = (rs1_val + imm_i) & ~32'd1;
         end
         7'b0110111: begin
            d_a = 32'd0;
            d_b = imm_u;
            d_rw = 1'b1;
         end
         7'b0010111: begin
            d_a = ifid_pc;
            d_b = imm_u;
            d_rw = 1'b1;
         end
         default: begin
            d_ill = 1'b1;
            d_a = 32'd0;
            d_b = 32'd0;
            d_rd = 5'd0;
         end
      endcase
   end

   // Stall has priority over any redirect; the branch re-evaluates after release.
   assign branch_taken = ifid_valid && !stall && !d_ill && (jump || cond);

   // ID/EX register: bubble on stall or empty IF/ID, otherwise the decoded bundle.
   always_ff @(posedge clk) begin
      if (reset || stall || !ifid_valid) begin
         id_ex_valid      <= 1'b0;
         id_ex_pc         <= 32'd0;
         id_ex_a          <= 32'd0;
         id_ex_b          <= 32'd0;
         id_ex_store_data <= 32'd0;
         id_ex_rd         <= 5'd0;
         id_ex_alu_op     <= 4'd0;
         id_ex_funct3     <= 3'd0;
         id_ex_mem_read   <= 1'b0;
         id_ex_mem_write  <= 1'b0;
         id_ex_reg_write  <= 1'b0;
         id_ex_illegal    <= 1'b0;
      end else begin
         id_ex_valid      <= 1'b1;
         id_ex_pc         <= ifid_pc;
         id_ex_a          <= d_a;
         id_ex_b          <= d_b;
         id_ex_store_data <= rs2_val;
         id_ex_rd         <= d_rd;
         id_ex_alu_op     <= d_op;
         id_ex_funct3     <= funct3;
         id_ex_mem_read   <= d_mr;
         id_ex_mem_write  <= d_mw;
         id_ex_reg_write  <= d_rw;
         id_ex_illegal    <= d_ill;
      end
   end
endmodule

// File: doc/decode_stage.md
# decode_stage

Second pipeline stage of the 32-bit RV32I core, directly downstream of instruction fetch. Registers the fetched instruction/PC (IF/ID), decodes it, reads the 32×32 register file, and resolves branches and jumps. Taken branches are returned to fetch via `branch_taken`/`branch_target`. Produces a registered ID/EX bundle with pre-muxed ALU operands and control for the execute stage.

## Interface
- No parameters. XLEN is fixed at 32 and the register count at 32.
- `clk` in 1: single clock, posedge.
- `reset` in 1: synchronous, active-high.
- `if_instruction` in 32: instruction word from fetch for `if_pc`.
- `if_pc` in 32: current fetch PC.
- `stall` in 1: hazard-unit stall. The hazard unit applies the same signal to the fetch PC.
- `wb_we` in 1: write-back enable.
- `wb_rd` in 5: write-back destination.
- `wb_data` in 32: write-back value.
- `branch_taken` out 1: combinational redirect to fetch.
- `branch_target` out 32: combinational redirect PC.
- `id_ex_valid` out 1: ID/EX holds a real instruction.
- `id_ex_pc` out 32: PC of that instruction.
- `id_ex_a` out 32: ALU operand A.
- `id_ex_b` out 32: ALU operand B.
- `id_ex_store_data` out 32: rs2 value for stores.
- `id_ex_rd` out 5: destination register.
- `id_ex_alu_op` out 4: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
- `id_ex_funct3` out 3: load/store width and sign.
- `id_ex_mem_read`, `id_ex_mem_write`, `id_ex_reg_write` out 1 each.
- `id_ex_illegal` out 1: unsupported opcode.

## Operation
- **IF/ID register** (`ifid_valid`, `ifid_instr`, `ifid_pc`):
  - Reset: valid=0, instr=0x00000013, pc=0.
  - `stall`=1: hold all fields.
  - Otherwise: capture `if_instruction`/`if_pc`, with valid = !`branch_taken`. This squashes the wrong-path instruction fetched behind a taken branch.
- **Register file:**
  - Write at posedge when `wb_we` && `wb_rd`!=0.
  - x0 always reads 0.
  - Read is combinational with write-through bypass: if `wb_we` && `wb_rd`==rs && rs!=0, return `wb_data`.
  - Reset clears all 32 entries.
- **Immediates:** I, S, B, U, J in standard RV32I formats, sign-extended.
- **Decode by opcode.** Any unlisted opcode is illegal: valid=1, illegal=1, reg_write/mem_read/mem_write=0, no redirect.
  - `0110011` R-type: a=rs1, b=rs2. alu_op from funct3 and funct7[5]: SUB for 000/1, SRA for 101/1. reg_write.
  - `0010011` I-ALU: a=rs1, b=immI. funct7[5] selects SRA only for funct3=101. reg_write.
  - `0000011` LOAD: a=rs1, b=immI, ADD, mem_read, reg_write.
  - `0100011` STORE: a=rs1, b=immS, ADD, mem_write, store_data=rs2. rd=0.
  - `1100011` BRANCH: compare rs1 against rs2 (BEQ, BNE, BLT, BGE, BLTU, BGEU). target = pc+immB. No writes; funct3 010/011 is illegal.
  - `1101111` JAL: a=pc, b=4, ADD, reg_write. Always taken, target = pc+immJ.
  - `1100111` JALR: a=pc, b=4, ADD, reg_write. Always taken, target = (rs1+immI) & ~1.
  - `0110111` LUI: a=0, b=immU, ADD, reg_write.
  - `0010111` AUIPC: a=pc, b=immU, ADD, reg_write.
- **Redirect:** `branch_taken` = ifid_valid && !stall && !illegal && (jump || branch condition true).
  - Comparisons use the bypassed register values.
  - No forwarding from EX/MEM; the hazard unit must stall instead.
- **ID/EX register:**
  - Reset: valid=0 and all fields 0.
  - If `stall` or !ifid_valid: insert a bubble (valid=0, reg_write=mem_read=mem_write=illegal=0; other fields don't-care, driven 0).
  - Otherwise: load the decoded bundle with valid=1.
- All adds are modulo 2^32.

## Timing
- Decode-to-ID/EX latency is 1 cycle after an instruction enters IF/ID.
- `branch_taken`/`branch_target` are combinational from IF/ID in the same cycle. Fetch updates its PC at that edge.
- Taken-branch penalty is exactly 1 bubble: the next ID/EX after the branch's successor slot is invalid.
- A write-back in cycle n is visible to a decode in the same cycle n through the bypass.
- Branch and stall in the same cycle: `stall` wins. There is no redirect, and the branch re-evaluates when the stall releases.
- `reset` asserted mid-operation: at the next edge, IF/ID, ID/EX and the register file are cleared. `branch_taken`=0 the following cycle.
- PC wrap: a target at 0xFFFFFFFC+8 yields 0x00000004.

## Test plan
- Reset, then present ADDI x2,x0,2 (0x00200113) at pc 0 → 2 cycles later: id_ex_valid=1, a=0, b=2, alu_op=0, rd=2, reg_write=1.
- Write x1=5 via wb in the same cycle that ADD x5,x1,x3 (0x003082B3) is in IF/ID (x3=7) → id_ex_a=5, id_ex_b=7 (bypass).
- BEQ x0,x0,+8 (0x00000463) at pc 0x10 → branch_taken=1, target=0x18. The next captured IF/ID is invalid, giving one ID/EX bubble.
- JALR x1,4(x2) with x2=0x101 → target=0x104, id_ex_a=pc, b=4, reg_write=1, rd=1.
- Hold `stall`=1 for 3 cycles with BNE taken in IF/ID → branch_taken=0 and ID/EX valid=0 throughout. After release: branch_taken=1 for one cycle, and the IF/ID contents are unchanged across the stall.
- Opcode 0x0000007F → id_ex_valid=1, illegal=1, no writes, branch_taken=0. Write to x0 via wb, then read x0 → 0.
